// File: rtl/bank_ctrl_6509.sv
// rtl/bank_ctrl_6509.sv - 6509-style execution/indirect bank controller for 6502-class CPUs
// Snoops zero-page register writes and switches to the indirect bank during (zp),Y data cycles.
module bank_ctrl_6509 #(
  parameter int unsigned           BANK_WIDTH = 4,
  parameter logic [15:0]           EXEC_ADDR  = 16'h0000,
  parameter logic [15:0]           IND_ADDR   = 16'h0001,
  parameter logic [BANK_WIDTH-1:0] RESET_BANK = {BANK_WIDTH{1'b1}},
  parameter int                    MODE       = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  r_w,
  input  logic [15:0]           address_cpu,
  inout  wire  [7:0]            data_cpu,
  input  logic                  rdy,
  input  logic                  sync,
  output logic [BANK_WIDTH-1:0] address_bank
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPR  = 3'd1,
    PTRL = 3'd2,
    PTRH = 3'd3,
    ACC1 = 3'd4,
    ACC2 = 3'd5
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [BANK_WIDTH-1:0] exec_bank;
  logic [BANK_WIDTH-1:0] ind_bank;
  logic                  exec_hit;
  logic                  ind_hit;
  logic                  opcode_match;
  logic [7:0]            read_data;

  assign exec_hit = (address_cpu == EXEC_ADDR);
  assign ind_hit  = (address_cpu == IND_ADDR);

  // Registers are visible in every bank; the RAM write underneath still happens.
  always_ff @(posedge clock) begin
    if (reset) begin
      exec_bank <= RESET_BANK;
      ind_bank  <= RESET_BANK;
    end else if (!r_w) begin
      if (exec_hit) exec_bank <= data_cpu[BANK_WIDTH-1:0];
      if (ind_hit)  ind_bank  <= data_cpu[BANK_WIDTH-1:0];
    end
  end

  always_comb begin
    read_data = 8'h00;
    if (exec_hit) read_data[BANK_WIDTH-1:0] = exec_bank;
    else          read_data[BANK_WIDTH-1:0] = ind_bank;
  end

  assign data_cpu = (r_w && clock && (exec_hit || ind_hit)) ? read_data : 8'bz;

  always_comb begin
    if (MODE != 0) opcode_match = (data_cpu[4:0] == 5'b10001);
    else           opcode_match = (data_cpu == 8'h91) || (data_cpu == 8'hB1);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // An opcode fetch always restarts tracking, whatever step the sequence is in.
  always_comb begin
    state_next   = state;
    address_bank = exec_bank;
    if (sync && rdy) begin
      state_next = opcode_match ? OPR : IDLE;
    end else if (rdy && !sync) begin
      case (state)
        OPR:     state_next = PTRL;
        PTRL:    state_next = PTRH;
        PTRH:    state_next = ACC1;
        ACC1:    state_next = ACC2;
        ACC2:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
    if (state == ACC1 || (state == ACC2 && !sync)) address_bank = ind_bank;
  end

endmodule

// File: tb/tb_bank_ctrl_6509.sv
// tb/tb_bank_ctrl_6509.sv - scoreboard bench for bank_ctrl_6509 in three parameterisations
module tb_bank_ctrl_6509;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        r_w = 1'b1;
  logic        rdy = 1'b1;
  logic        sync = 1'b0;
  logic        tb_oe = 1'b0;
  logic [15:0] address_cpu = 16'h0000;
  logic [7:0]  tb_data = 8'h00;
  wire  [7:0]  data0;
  wire  [7:0]  data1;
  wire  [7:0]  data2;
  logic [3:0]  bank0;
  logic [3:0]  bank1;
  logic [7:0]  bank2;

  always #5 clock = ~clock;

  // Undriven bus reads as 8'hFF, so a released bus is distinguishable from readback.
  assign data0 = tb_oe ? tb_data : 8'bz;
  assign data1 = tb_oe ? tb_data : 8'bz;
  assign data2 = tb_oe ? tb_data : 8'bz;
  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (data0[i]);
    pullup (data1[i]);
    pullup (data2[i]);
  end

  bank_ctrl_6509 #(.MODE(0)) dut0 (
    .clock(clock), .reset(reset), .r_w(r_w), .address_cpu(address_cpu),
    .data_cpu(data0), .rdy(rdy), .sync(sync), .address_bank(bank0));

  bank_ctrl_6509 #(.MODE(1)) dut1 (
    .clock(clock), .reset(reset), .r_w(r_w), .address_cpu(address_cpu),
    .data_cpu(data1), .rdy(rdy), .sync(sync), .address_bank(bank1));

  bank_ctrl_6509 #(.BANK_WIDTH(8), .EXEC_ADDR(16'h0010), .MODE(0)) dut2 (
    .clock(clock), .reset(reset), .r_w(r_w), .address_cpu(address_cpu),
    .data_cpu(data2), .rdy(rdy), .sync(sync), .address_bank(bank2));

  typedef struct {
    int         cyc;
    int         dut;
    bit         is_data;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [7:0] sample(input int dut, input bit is_data);
    case (dut)
      0:       return is_data ? data0 : {4'h0, bank0};
      1:       return is_data ? data1 : {4'h0, bank1};
      default: return is_data ? data2 : bank2;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      #3;
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
        exp_t       e;
        logic [7:0] act;
        e   = exp_q.pop_front();
        act = sample(e.dut, e.is_data);
        n_cmp++;
        if (act !== e.val) begin
          n_bad++;
          $display("FAIL %s dut%0d %s cycle %0d: got %h expected %h",
                   e.name, e.dut, e.is_data ? "data" : "bank", e.cyc, act, e.val);
        end
      end
    end
  end

  task automatic push(input int dut, input bit is_data, input logic [7:0] v, input string name);
    exp_t e;
    e = '{cyc_cnt, dut, is_data, v, name};
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit rw, input logic [15:0] a, input bit drv,
                     input logic [7:0] d, input bit s, input bit r,
                     input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input string name);
    @(posedge clock);
    #1;
    reset = rst; r_w = rw; address_cpu = a; tb_oe = drv; tb_data = d; sync = s; rdy = r;
    cyc_cnt++;
    push(0, 1'b0, b0, name);
    push(1, 1'b0, b1, name);
    push(2, 1'b0, b2, name);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b2,
                    input logic [7:0] r0, input logic [7:0] r2, input string name);
    cyc(1'b0, 1'b1, a, 1'b0, 8'h00, 1'b0, 1'b1, b0, b0, b2, name);
    push(0, 1'b1, r0, name);
    push(1, 1'b1, r0, name);
    push(2, 1'b1, r2, name);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d,
                    input logic [7:0] b0, input logic [7:0] b2, input string name);
    cyc(1'b0, 1'b0, a, 1'b1, d, 1'b0, 1'b1, b0, b0, b2, name);
  endtask

  task automatic bus(input logic [15:0] a, input logic [7:0] d, input bit s, input bit r,
                     input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input string name);
    cyc(1'b0, 1'b1, a, 1'b1, d, s, r, b0, b1, b2, name);
  endtask

  // Opcode fetch, operand fetch and both pointer reads: always the execution bank.
  task automatic head(input logic [7:0] op, input string name);
    bus(16'h0200, op,    1'b1, 1'b1, 8'h03, 8'h03, 8'hA5, {name, "_c1"});
    bus(16'h0201, 8'h40, 1'b0, 1'b1, 8'h03, 8'h03, 8'hA5, {name, "_c2"});
    bus(16'h0040, 8'h00, 1'b0, 1'b1, 8'h03, 8'h03, 8'hA5, {name, "_c3"});
    bus(16'h0041, 8'h30, 1'b0, 1'b1, 8'h03, 8'h03, 8'hA5, {name, "_c4"});
  endtask

  initial begin
    repeat (2) @(posedge clock);
    cyc(1'b1, 1'b1, 16'h0300, 1'b1, 8'hEA, 1'b0, 1'b1, 8'h0F, 8'h0F, 8'hFF, "reset_bank");

    rd(16'h0000, 8'h0F, 8'hFF, 8'h0F, 8'hFF, "rst_rd_exec");
    rd(16'h0001, 8'h0F, 8'hFF, 8'h0F, 8'hFF, "rst_rd_ind");
    rd(16'h0002, 8'h0F, 8'hFF, 8'hFF, 8'hFF, "hiz_0002");

    wr(16'h0000, 8'h03, 8'h0F, 8'hFF, "wr_exec_old");
    wr(16'h0001, 8'hF7, 8'h03, 8'hFF, "wr_ind_f7");
    rd(16'h0001, 8'h03, 8'hFF, 8'h07, 8'hF7, "rd_ind_masked");
    wr(16'h0001, 8'h05, 8'h03, 8'hFF, "wr_ind_05");
    wr(16'h0010, 8'hA5, 8'h03, 8'hFF, "wr_exec10");
    rd(16'h0000, 8'h03, 8'hA5, 8'h03, 8'hFF, "rd_exec");
    rd(16'h0001, 8'h03, 8'hA5, 8'h05, 8'h05, "rd_ind");
    rd(16'h0010, 8'h03, 8'hA5, 8'hFF, 8'hA5, "rd_exec10");

    head(8'hB1, "lda");
    bus(16'h3005, 8'h11, 1'b0, 1'b1, 8'h05, 8'h05, 8'h05, "lda_c5");
    bus(16'h0202, 8'hEA, 1'b1, 1'b1, 8'h03, 8'h03, 8'hA5, "lda_c6");
    bus(16'h0203, 8'h00, 1'b0, 1'b1, 8'h03, 8'h03, 8'hA5, "lda_c7");

    head(8'hB1, "ldax");
    bus(16'h3005, 8'h11, 1'b0, 1'b1, 8'h05, 8'h05, 8'h05, "ldax_c5");
    bus(16'h3105, 8'h22, 1'b0, 1'b1, 8'h05, 8'h05, 8'h05, "ldax_c6");
    bus(16'h0202, 8'hEA, 1'b1, 1'b1, 8'h03, 8'h03, 8'hA5, "ldax_c7");

    head(8'h91, "sta");
    bus(16'h3005, 8'h11, 1'b0, 1'b1, 8'h05, 8'h05, 8'h05, "sta_c5");
    wr(16'h3005, 8'h77, 8'h05, 8'h05, "sta_c6");
    bus(16'h0202, 8'hEA, 1'b1, 1'b1, 8'h03, 8'h03, 8'hA5, "sta_c7");

    bus(16'h0200, 8'h91, 1'b1, 1'b1, 8'h03, 8'h03, 8'hA5, "stall_c1");
    bus(16'h0201, 8'h40, 1'b0, 1'b1, 8'h03, 8'h03, 8'hA5, "stall_c2");
    bus(16'h0040, 8'h00, 1'b0, 1'b1, 8'h03, 8'h03, 8'hA5, "stall_c3");
    bus(16'h0041, 8'h30, 1'b0, 1'b0, 8'h03, 8'h03, 8'hA5, "stall_c4");
    bus(16'h0041, 8'h30, 1'b0, 1'b0, 8'h03, 8'h03, 8'hA5, "stall_c5");
    bus(16'h0041, 8'h30, 1'b0, 1'b1, 8'h03, 8'h03, 8'hA5, "stall_c6");
    bus(16'h3005, 8'h11, 1'b0, 1'b1, 8'h05, 8'h05, 8'h05, "stall_c7");
    wr(16'h3005, 8'h77, 8'h05, 8'h05, "stall_c8");
    bus(16'h0202, 8'hEA, 1'b1, 1'b1, 8'h03, 8'h03, 8'hA5, "stall_c9");

    head(8'h71, "adc");
    bus(16'h3005, 8'h11, 1'b0, 1'b1, 8'h03, 8'h05, 8'hA5, "adc_c5");
    bus(16'h0202, 8'hEA, 1'b1, 1'b1, 8'h03, 8'h03, 8'hA5, "adc_c6");

    head(8'hB1, "indwr");
    wr(16'h0001, 8'h09, 8'h05, 8'h05, "indwr_c5");
    bus(16'h3105, 8'h22, 1'b0, 1'b1, 8'h09, 8'h09, 8'h09, "indwr_c6");
    bus(16'h0202, 8'hEA, 1'b1, 1'b1, 8'h03, 8'h03, 8'hA5, "indwr_c7");
    rd(16'h0001, 8'h03, 8'hA5, 8'h09, 8'h09, "indwr_rd");

    head(8'hB1, "rst");
    cyc(1'b1, 1'b1, 16'h3005, 1'b1, 8'h11, 1'b0, 1'b1, 8'h09, 8'h09, 8'h09, "rst_c5");
    bus(16'h0202, 8'hEA, 1'b1, 1'b1, 8'h0F, 8'h0F, 8'hFF, "rst_c6");
    rd(16'h0000, 8'h0F, 8'hFF, 8'h0F, 8'hFF, "rst_c7_rd");

    repeat (2) @(posedge clock);
    #5;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
